// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/mem-stage arbiter for one single-port RAM; optional fetch starvation guard via MEM_ARB_STARVE_GUARD_EN
module mem_bus_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req_i,
    input  logic [31:0] inst_addr_i,
    output logic        inst_gnt_o,
    output logic        inst_rvalid_o,
    output logic [31:0] inst_rdata_o,
    input  logic        flush_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_sel_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    output logic        stallreq_if_o,
    output logic        stallreq_mem_o
);

    if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_MAX < 1) begin : g_param_check
        $error("mem_bus_arbiter: MEM_LAT must be 1..4 and STARVE_MAX >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_e;

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;      // 1 = data port owns the transaction
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        drop_q, drop_d;

    logic run, resp, win, issue, any_gnt, force_fetch;
    logic fetch_out, data_out;

    // Outputs are gated by the reset input so they fall the moment reset asserts.
    assign run     = rst;
    assign resp    = (state_q == S_WAIT) && (cnt_q == 2'd0);
    assign win     = run && ((state_q == S_IDLE) || resp);
    assign issue   = run && (state_q == S_ISSUE);

    assign data_gnt_o = win && data_req_i && !force_fetch;
    assign inst_gnt_o = win && inst_req_i && !data_gnt_o;
    assign any_gnt    = inst_gnt_o || data_gnt_o;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q, starve_d;

    assign force_fetch = (starve_q == SW'(STARVE_MAX)) && inst_req_i && data_req_i;

    always_comb begin
        starve_d = starve_q;
        if (inst_gnt_o) begin
            starve_d = '0;
        end else if (data_gnt_o && inst_req_i) begin
            starve_d = starve_q + 1'b1;
        end else if (win && !inst_req_i) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_fetch = 1'b0;
`endif

    assign ram_ce_o    = issue;
    assign ram_we_o    = issue && we_q;
    assign ram_sel_o   = issue ? sel_q   : 4'b0000;
    assign ram_addr_o  = issue ? addr_q  : 32'h0;
    assign ram_wdata_o = issue ? wdata_q : 32'h0;

    // A flush seen in the response cycle itself still kills that fetch.
    assign inst_rvalid_o = run && resp && !owner_q && !drop_q && !flush_i;
    assign inst_rdata_o  = (run && resp && !owner_q) ? ram_rdata_i : 32'h0;
    assign data_rvalid_o = run && resp && owner_q;
    assign data_rdata_o  = data_rvalid_o ? ram_rdata_i : 32'h0;

    assign fetch_out      = !owner_q && ((state_q == S_ISSUE) || ((state_q == S_WAIT) && (cnt_q != 2'd0)));
    assign data_out       = owner_q && (state_q != S_IDLE);
    assign stallreq_if_o  = run && ((inst_req_i && !inst_gnt_o) || fetch_out);
    assign stallreq_mem_o = run && (data_req_i || data_out) && !data_rvalid_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        we_d    = we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        drop_d  = drop_q;

        case (state_q)
            S_IDLE:  if (any_gnt) state_d = S_ISSUE;
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = CNT_INIT;
            end
            S_WAIT: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    state_d = any_gnt ? S_ISSUE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (any_gnt) begin
            owner_d = data_gnt_o;
            we_d    = data_gnt_o && data_we_i;
            sel_d   = data_gnt_o ? data_sel_i : 4'b1111;
            addr_d  = data_gnt_o ? data_addr_i : inst_addr_i;
            wdata_d = data_gnt_o ? data_wdata_i : 32'h0;
            drop_d  = 1'b0;
        end else if ((state_q != S_IDLE) && !owner_q && flush_i) begin
            drop_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'b0000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter with MEM_LAT = 2
module tb_mem_bus_arbiter;

    localparam int LAT = 2;
    localparam int SMAX = 4;
    localparam logic [31:0] KEY = 32'hA5A5_1334;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_i, flush_i, data_req_i, data_we_i;
    logic [31:0] inst_addr_i, data_addr_i, data_wdata_i;
    logic [3:0]  data_sel_i;
    logic        inst_gnt_o, inst_rvalid_o, data_gnt_o, data_rvalid_o;
    logic [31:0] inst_rdata_o, data_rdata_o;
    logic        ram_ce_o, ram_we_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
    logic        stallreq_if_o, stallreq_mem_o;

    typedef struct {
        bit          is_data;
        bit          chk;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] rd_addr = 32'h0;

    mem_bus_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_gnt_o(inst_gnt_o),
        .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o), .flush_i(flush_i),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_sel_i(data_sel_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
        .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o)
    );

    always #5 clk = ~clk;

    // RAM model: read data is a fixed function of the last read address issued.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_ce_o && !ram_we_o) rd_addr <= ram_addr_o;
    end
    assign ram_rdata_i = rd_addr ^ KEY;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rvalid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (inst_rvalid_o || data_rvalid_o) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        inst_req_i = 1'b1; data_req_i = 1'b1;
        repeat (2) step();
        n_cmp++;
        if ({ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, inst_gnt_o, data_gnt_o, inst_rvalid_o,
             data_rvalid_o, stallreq_if_o, stallreq_mem_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: ce=%0b gnt=%0b%0b rv=%0b%0b stall=%0b%0b want all 0", ram_ce_o,
                     inst_gnt_o, data_gnt_o, inst_rvalid_o, data_rvalid_o, stallreq_if_o, stallreq_mem_o);
        end
        inst_req_i = 1'b0; data_req_i = 1'b0;
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_load();
        exp_t e; int t; bit seen;
        step();
        data_req_i = 1'b1; data_we_i = 1'b0; data_sel_i = 4'b0100; data_addr_i = 32'h100;
        #1;
        n_cmp++;
        if (data_gnt_o !== 1'b1 || inst_gnt_o !== 1'b0) begin
            n_bad++; $display("FAIL load_gnt: got d=%0b i=%0b want d=1 i=0", data_gnt_o, inst_gnt_o);
        end
        t = cyc;
        sb.push_back('{1'b1, 1'b1, 32'h100 ^ KEY, t + 1 + LAT});
        step();
        data_req_i = 1'b0;
        #1;
        n_cmp++;
        if (ram_ce_o !== 1'b1 || ram_we_o !== 1'b0 || ram_sel_o !== 4'b0100 || ram_addr_o !== 32'h100) begin
            n_bad++; $display("FAIL load_issue: ce=%0b we=%0b sel=%b addr=%h want 1 0 0100 100",
                              ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o);
        end
        wait_rvalid(10, seen);
        n_cmp++;
        if (!seen || sb.size() == 0) begin
            n_bad++; $display("FAIL load_timeout: no rvalid within budget");
        end else begin
            e = sb.pop_front();
            if (data_rvalid_o !== 1'b1 || cyc !== e.due || data_rdata_o !== e.rdata ||
                inst_rdata_o !== 32'h0 || stallreq_mem_o !== 1'b0) begin
                n_bad++; $display("FAIL load_resp: rv=%0b cyc=%0d rdata=%h irdata=%h stall=%0b want 1 %0d %h 0 0",
                                  data_rvalid_o, cyc, data_rdata_o, inst_rdata_o, stallreq_mem_o, e.due, e.rdata);
            end
        end
    endtask

    task automatic test_store();
        exp_t e; int t; bit seen;
        step();
        data_req_i = 1'b1; data_we_i = 1'b1; data_sel_i = 4'b0011;
        data_addr_i = 32'h204; data_wdata_i = 32'h5678_5678;
        #1;
        n_cmp++;
        if (data_gnt_o !== 1'b1) begin n_bad++; $display("FAIL store_gnt: got %0b want 1", data_gnt_o); end
        t = cyc;
        sb.push_back('{1'b1, 1'b0, 32'h0, t + 1 + LAT});
        step();
        data_req_i = 1'b0; data_we_i = 1'b0;
        #1;
        n_cmp++;
        if (ram_we_o !== 1'b1 || ram_sel_o !== 4'b0011 || ram_wdata_o !== 32'h5678_5678 || ram_addr_o !== 32'h204) begin
            n_bad++; $display("FAIL store_issue: we=%0b sel=%b wdata=%h addr=%h want 1 0011 56785678 204",
                              ram_we_o, ram_sel_o, ram_wdata_o, ram_addr_o);
        end
        step();
        n_cmp++;
        if (ram_we_o !== 1'b0 || ram_ce_o !== 1'b0) begin
            n_bad++; $display("FAIL store_one_cycle: ce=%0b we=%0b want 0 0", ram_ce_o, ram_we_o);
        end
        wait_rvalid(10, seen);
        n_cmp++;
        if (!seen || sb.size() == 0) begin
            n_bad++; $display("FAIL store_timeout: no completion within budget");
        end else begin
            e = sb.pop_front();
            if (data_rvalid_o !== 1'b1 || inst_rvalid_o !== 1'b0 || cyc !== e.due) begin
                n_bad++; $display("FAIL store_resp: drv=%0b irv=%0b cyc=%0d want 1 0 %0d",
                                  data_rvalid_o, inst_rvalid_o, cyc, e.due);
            end
        end
    endtask

    task automatic test_fetch();
        exp_t e; int t; bit seen;
        step();
        inst_req_i = 1'b1; inst_addr_i = 32'h300;
        #1;
        n_cmp++;
        if (inst_gnt_o !== 1'b1 || data_gnt_o !== 1'b0) begin
            n_bad++; $display("FAIL fetch_gnt: got i=%0b d=%0b want 1 0", inst_gnt_o, data_gnt_o);
        end
        t = cyc;
        sb.push_back('{1'b0, 1'b1, 32'h300 ^ KEY, t + 1 + LAT});
        step();
        inst_req_i = 1'b0;
        #1;
        n_cmp++;
        if (ram_ce_o !== 1'b1 || ram_we_o !== 1'b0 || ram_sel_o !== 4'hF || ram_addr_o !== 32'h300 || stallreq_if_o !== 1'b1) begin
            n_bad++; $display("FAIL fetch_issue: ce=%0b we=%0b sel=%b addr=%h stall=%0b want 1 0 1111 300 1",
                              ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, stallreq_if_o);
        end
        wait_rvalid(10, seen);
        n_cmp++;
        if (!seen || sb.size() == 0) begin
            n_bad++; $display("FAIL fetch_timeout: no rvalid within budget");
        end else begin
            e = sb.pop_front();
            if (inst_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0 || cyc !== e.due ||
                inst_rdata_o !== e.rdata || data_rdata_o !== 32'h0) begin
                n_bad++; $display("FAIL fetch_resp: irv=%0b drv=%0b cyc=%0d rdata=%h drdata=%h want 1 0 %0d %h 0",
                                  inst_rvalid_o, data_rvalid_o, cyc, inst_rdata_o, data_rdata_o, e.due, e.rdata);
            end
        end
    endtask

    task automatic test_contention();
        exp_t e; int grants, last_t; bit fetch_done, gnt_now, fetch_now, exp_data;
        step();
        inst_req_i = 1'b1; inst_addr_i = 32'h800;
        data_req_i = 1'b1; data_we_i = 1'b0; data_sel_i = 4'hF; data_addr_i = 32'h400;
        #1;
        grants = 0; last_t = -1; fetch_done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (inst_rvalid_o || data_rvalid_o) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL cont_unexpected_rvalid: cycle %0d, queue empty", cyc);
                end else begin
                    e = sb.pop_front();
                    if (data_rvalid_o !== e.is_data || inst_rvalid_o === e.is_data || cyc !== e.due ||
                        (e.is_data ? data_rdata_o : inst_rdata_o) !== e.rdata) begin
                        n_bad++; $display("FAIL cont_resp: drv=%0b irv=%0b cyc=%0d want data=%0b due=%0d rdata=%h",
                                          data_rvalid_o, inst_rvalid_o, cyc, e.is_data, e.due, e.rdata);
                    end
                end
            end
            gnt_now  = inst_gnt_o || data_gnt_o;
            exp_data = !(GUARD && grants == SMAX);
            if (!fetch_done) begin
                n_cmp++;
                if (stallreq_if_o !== !(gnt_now && !exp_data)) begin
                    n_bad++; $display("FAIL cont_stall_if: cyc=%0d got %0b", cyc, stallreq_if_o);
                end
            end
            fetch_now = 1'b0;
            if (gnt_now) begin
                n_cmp++;
                if (data_gnt_o !== exp_data || inst_gnt_o !== !exp_data) begin
                    n_bad++; $display("FAIL cont_owner: grant %0d got d=%0b i=%0b want d=%0b",
                                      grants + 1, data_gnt_o, inst_gnt_o, exp_data);
                end
                if (last_t >= 0) begin
                    n_cmp++;
                    if (cyc - last_t != LAT + 1) begin
                        n_bad++; $display("FAIL cont_spacing: got %0d want %0d", cyc - last_t, LAT + 1);
                    end
                end
                last_t = cyc;
                sb.push_back('{exp_data, 1'b1, (exp_data ? data_addr_i : inst_addr_i) ^ KEY, cyc + 1 + LAT});
                grants++;
                fetch_now = !exp_data;
            end
            if (grants >= 5 && sb.size() == 0) break;
            step();
            if (gnt_now) begin
                data_addr_i = data_addr_i + 32'd4;
                if (fetch_now || grants >= 5) begin
                    inst_req_i = 1'b0; fetch_done = 1'b1;
                end
                if (grants >= 5) data_req_i = 1'b0;
            end
            #1;
            if (fetch_now) begin
                n_cmp++;
                if (ram_sel_o !== 4'hF || ram_we_o !== 1'b0 || ram_addr_o !== 32'h800) begin
                    n_bad++; $display("FAIL cont_fetch_issue: sel=%b we=%0b addr=%h want 1111 0 800",
                                      ram_sel_o, ram_we_o, ram_addr_o);
                end
            end
        end
        n_cmp++;
        if (grants != 5 || sb.size() != 0) begin
            n_bad++; $display("FAIL cont_done: grants=%0d pending=%0d want 5 0", grants, sb.size());
        end
        inst_req_i = 1'b0; data_req_i = 1'b0;
    endtask

    task automatic test_flush();
        exp_t e; int t; bit seen;
        step();
        inst_req_i = 1'b1; inst_addr_i = 32'h900;
        #1;
        n_cmp++;
        if (inst_gnt_o !== 1'b1) begin n_bad++; $display("FAIL flush_gnt: got %0b want 1", inst_gnt_o); end
        t = cyc;
        step();
        inst_req_i = 1'b0; flush_i = 1'b1;
        #1;
        step();
        flush_i = 1'b0;
        data_req_i = 1'b1; data_we_i = 1'b0; data_sel_i = 4'hF; data_addr_i = 32'hA40;
        #1;
        while (cyc < t + 1 + LAT) begin
            n_cmp++;
            if (data_gnt_o !== 1'b0) begin n_bad++; $display("FAIL flush_early_gnt: cyc=%0d got 1 want 0", cyc); end
            step();
        end
        n_cmp++;
        if (data_gnt_o !== 1'b1 || inst_rvalid_o !== 1'b0) begin
            n_bad++; $display("FAIL flush_resp_cycle: dgnt=%0b irv=%0b want 1 0", data_gnt_o, inst_rvalid_o);
        end
        sb.push_back('{1'b1, 1'b1, 32'hA40 ^ KEY, cyc + 1 + LAT});
        step();
        data_req_i = 1'b0;
        #1;
        n_cmp++;
        if (ram_ce_o !== 1'b1 || ram_addr_o !== 32'hA40 || cyc !== t + 2 + LAT) begin
            n_bad++; $display("FAIL flush_data_issue: ce=%0b addr=%h cyc=%0d want 1 a40 %0d",
                              ram_ce_o, ram_addr_o, cyc, t + 2 + LAT);
        end
        wait_rvalid(10, seen);
        n_cmp++;
        if (!seen || sb.size() == 0) begin
            n_bad++; $display("FAIL flush_timeout: no rvalid within budget");
        end else begin
            e = sb.pop_front();
            if (data_rvalid_o !== 1'b1 || inst_rvalid_o !== 1'b0 || cyc !== e.due || data_rdata_o !== e.rdata) begin
                n_bad++; $display("FAIL flush_data_resp: drv=%0b irv=%0b cyc=%0d rdata=%h want 1 0 %0d %h",
                                  data_rvalid_o, inst_rvalid_o, cyc, data_rdata_o, e.due, e.rdata);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e; int t; bit seen;
        step();
        data_req_i = 1'b1; data_we_i = 1'b0; data_sel_i = 4'hF; data_addr_i = 32'hB00;
        #1;
        step();
        inst_req_i = 1'b1;
        #1;
        n_cmp++;
        if (ram_ce_o !== 1'b1) begin n_bad++; $display("FAIL areset_pre_issue: ce=%0b want 1", ram_ce_o); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, inst_gnt_o, data_gnt_o, inst_rvalid_o,
             data_rvalid_o, stallreq_if_o, stallreq_mem_o} !== '0) begin
            n_bad++; $display("FAIL areset_outputs: ce=%0b gnt=%0b%0b rv=%0b%0b stall=%0b%0b want all 0", ram_ce_o,
                              inst_gnt_o, data_gnt_o, inst_rvalid_o, data_rvalid_o, stallreq_if_o, stallreq_mem_o);
        end
        repeat (2) step();
        rst = 1'b1; inst_req_i = 1'b0; data_addr_i = 32'hB40;
        #1;
        n_cmp++;
        if (data_gnt_o !== 1'b1) begin n_bad++; $display("FAIL areset_regrant: got %0b want 1", data_gnt_o); end
        t = cyc;
        sb.push_back('{1'b1, 1'b1, 32'hB40 ^ KEY, t + 1 + LAT});
        step();
        data_req_i = 1'b0;
        #1;
        wait_rvalid(10, seen);
        n_cmp++;
        if (!seen || sb.size() == 0) begin
            n_bad++; $display("FAIL areset_timeout: no rvalid within budget");
        end else begin
            e = sb.pop_front();
            if (data_rvalid_o !== 1'b1 || cyc !== e.due || data_rdata_o !== e.rdata) begin
                n_bad++; $display("FAIL areset_resp: rv=%0b cyc=%0d rdata=%h want 1 %0d %h",
                                  data_rvalid_o, cyc, data_rdata_o, e.due, e.rdata);
            end
        end
    endtask

    initial begin
        rst = 1'b0; flush_i = 1'b0;
        inst_req_i = 1'b0; inst_addr_i = 32'h0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_sel_i = 4'h0;
        data_addr_i = 32'h0; data_wdata_i = 32'h0;
        test_reset();
        test_single_load();
        test_store();
        test_fetch();
        test_contention();
        test_flush();
        test_async_reset();
        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
